// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants shared by raster and sprite stages
package vga_timing_pkg;
  localparam int CNT_W = 10;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: reset-to-inactive shift register aligning sync with the pixel pipeline
module vga_sync_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '1;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, registered blank/strobe decode and delayed hs/vs
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start
);
  import vga_timing_pkg::*;
  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_START + V_SYNC;
  if (H_TOT > 1024 || V_TOT > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_cfg
    $error("vga_timing_gen: totals must fit 10-bit counters and SYNC_DELAY must be 0..7");
  end
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic h_wrap, hs_i, vs_i;
  logic [1:0] sync_q;
  assign h_wrap = h_cnt == CNT_W'(H_TOT - 1);
  always_comb begin
    h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt = !h_wrap ? v_cnt : (v_cnt == CNT_W'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
    hs_i = !(h_cnt >= CNT_W'(HS_START) && h_cnt < CNT_W'(HS_END));
    vs_i = !(v_cnt >= CNT_W'(VS_START) && v_cnt < CNT_W'(VS_END));
  end
  // Decode from next-state counts so the flags land on the same edge as DrawX/DrawY
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      blank <= 1'b1;
      frame_start <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      blank <= h_nxt < CNT_W'(H_VISIBLE) && v_nxt < CNT_W'(V_VISIBLE);
      frame_start <= h_nxt == '0 && v_nxt == '0;
      vblank_start <= h_nxt == '0 && v_nxt == CNT_W'(V_VISIBLE);
    end
  end
  assign DrawX = h_cnt;
  assign DrawY = v_cnt;
  vga_sync_delay #(.WIDTH(2), .DEPTH(SYNC_DELAY)) u_sync (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .d({hs_i, vs_i}),
    .q(sync_q)
  );
  assign {hs, vs} = sync_q;
endmodule
